// File: rtl/tick_down_timer.sv
// ---------------------------------------------------------------------------
// tick_down_timer
//
// Game/round countdown timer fed by the free-running tick counter. After a
// start pulse it loads START and then removes one unit from the count every
// DIV accepted input ticks. When the count reaches zero it enters DONE,
// raises the sticky done flag and emits a single-cycle expired pulse.
// While pause is high, ticks are ignored and a partially accumulated step is
// kept in the prescaler.
//
// Parameters
//   WIDTH  bit width of the count
//   START  reload value on start (1 .. 2^WIDTH-1)
//   DIV    input ticks per count step (>= 1)
//
// Ports
//   clk      system clock, all state changes on posedge
//   reset    synchronous active-high reset
//   tick     single-cycle enable pulse from the tick counter
//   start    loads START and begins or restarts counting
//   pause    level; while high, ticks are ignored
//   count    remaining time (registered)
//   running  high in RUN
//   done     high in DONE, sticky until start or reset
//   expired  one-cycle pulse on the RUN->DONE transition
// ---------------------------------------------------------------------------
module tick_down_timer #(
    parameter int WIDTH = 8,
    parameter int START = 99,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    // Prescaler is at least one bit wide so DIV=1 still has a legal vector.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0]    PRESC_MAX = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] START_V   = WIDTH'(START);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] presc;

    // Decrement that floors at zero; the count must never wrap.
    function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= START_V;
            presc   <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            // expired is a pulse: cleared every cycle unless re-asserted below.
            expired <= 1'b0;

            if (start) begin
                // start wins over pause and tick; a same-cycle tick is dropped.
                state   <= RUN;
                count   <= START_V;
                presc   <= '0;
                running <= 1'b1;
                done    <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        // Waiting for start; count already holds START.
                    end

                    RUN: begin
                        if (pause) begin
                            // Same-cycle tick is discarded; presc is kept.
                            state   <= PAUSED;
                            running <= 1'b0;
                        end else if (tick) begin
                            if (presc != PRESC_MAX) begin
                                presc <= presc + 1'b1;
                            end else begin
                                presc <= '0;
                                if (count > WIDTH'(1)) begin
                                    count <= sat_dec(count);
                                end else begin
                                    count   <= '0;
                                    state   <= DONE;
                                    running <= 1'b0;
                                    done    <= 1'b1;
                                    expired <= 1'b1;
                                end
                            end
                        end
                    end

                    PAUSED: begin
                        // Leaving pause ignores the tick of that same cycle.
                        if (!pause) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    DONE: begin
                        // Only start or reset leave DONE.
                    end

                    default: begin
                        state   <= IDLE;
                        running <= 1'b0;
                        done    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tick_down_timer.sv
// ---------------------------------------------------------------------------
// tb_tick_down_timer
//
// Directed bench for tick_down_timer with DIV=2, START=3. Inputs are driven
// 1 time unit after each rising edge and outputs are sampled there as well,
// so each step() call corresponds to exactly one sampled clock edge.
// ---------------------------------------------------------------------------
module tb_tick_down_timer;

    localparam int WIDTH = 8;
    localparam int START = 3;
    localparam int DIV   = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             tick = 1'b0;
    logic             start = 1'b0;
    logic             pause = 1'b0;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             done;
    logic             expired;

    int total = 0;
    int bad   = 0;

    tick_down_timer #(
        .WIDTH(WIDTH),
        .START(START),
        .DIV  (DIV)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .start  (start),
        .pause  (pause),
        .count  (count),
        .running(running),
        .done   (done),
        .expired(expired)
    );

    always #5 clk = ~clk;

    // Apply inputs, clock one edge, and settle past it.
    task automatic step(input logic r, input logic t, input logic s, input logic p);
        reset = r;
        tick  = t;
        start = s;
        pause = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Check all four outputs at once.
    task automatic chk_all(input string tag, input int c, input int r, input int d, input int e);
        chk({tag, ".count"},   int'(count),   c);
        chk({tag, ".running"}, int'(running), r);
        chk({tag, ".done"},    int'(done),    d);
        chk({tag, ".expired"}, int'(expired), e);
    endtask

    initial begin
        #1;

        // 1. Reset, then ticks in IDLE do nothing.
        step(1, 0, 0, 0);
        chk_all("reset", 3, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 1);
            chk_all("idle_tick", 3, 0, 0, 0);
        end

        // 2. Full run: start, then tick every cycle.
        step(0, 1, 1, 0);
        chk_all("start1", 3, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t1", 3, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t2", 2, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t3", 2, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t4", 1, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t5", 1, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("run_t6_expire", 0, 0, 1, 1);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 0, 0);
            chk_all("done_hold", 0, 0, 1, 0);
        end

        // 3. Pause keeps count and partial prescaler progress.
        step(0, 0, 1, 0); chk_all("start2", 3, 1, 0, 0);
        step(0, 1, 0, 0); chk("p_t1.count", int'(count), 3);
        step(0, 1, 0, 0); chk("p_t2.count", int'(count), 2);
        step(0, 1, 0, 0); chk("p_t3.count", int'(count), 2);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 0, 1);
            chk_all("paused", 2, 0, 0, 0);
        end
        step(0, 1, 0, 0); chk_all("unpause_ignored_tick", 2, 1, 0, 0);
        step(0, 1, 0, 0); chk_all("presc_retained", 1, 1, 0, 0);

        // 4. Restart mid-run with a simultaneous tick.
        step(0, 1, 1, 0); chk_all("restart_run", 3, 1, 0, 0);
        step(0, 1, 0, 0); chk("restart_presc0_a", int'(count), 3);
        step(0, 1, 0, 0); chk("restart_presc0_b", int'(count), 2);

        // 5. Finish the run, then restart from DONE.
        step(0, 1, 0, 0); chk("to_done_a", int'(count), 2);
        step(0, 1, 0, 0); chk("to_done_b", int'(count), 1);
        step(0, 1, 0, 0); chk("to_done_c", int'(count), 1);
        step(0, 1, 0, 0); chk_all("to_done_expire", 0, 0, 1, 1);
        step(0, 0, 0, 0); chk_all("done_idle_cycle", 0, 0, 1, 0);
        step(0, 0, 1, 0); chk_all("restart_done", 3, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 0, 0);
            chk("rerun.expired", int'(expired), 0);
        end
        step(0, 1, 0, 0); chk_all("rerun_expire", 0, 0, 1, 1);
        step(0, 0, 0, 0); chk_all("rerun_after", 0, 0, 1, 0);

        // 6. Reset mid-run aborts without an expired pulse.
        step(0, 0, 1, 0); chk_all("start3", 3, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0); chk("pre_reset.count", int'(count), 2);
        step(1, 1, 0, 0); chk_all("reset_mid", 3, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            chk_all("post_reset_tick", 3, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the bench can never hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
